x_window_sym_fir: RTL and testbench

//  Parametrised horizontal (x) symmetric FIR for the separable window filter stage.

---
 rtl/x_window_pkg.sv | 14 +
 rtl/xwin_sym_mac.sv | 39 +++
 rtl/x_window_sym_fir.sv | 121 ++++++++++++
 tb/tb_x_window_sym_fir.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/x_window_pkg.sv
// x_window_pkg: shared FSM state, width helpers and default Gaussian taps for the x-window FIR.
package x_window_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam logic [23:0] DEF_COEFS = 24'h803A06;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r < 1 ? 1 : r;
  endfunction
  function automatic int sum_w(input int dw, input int cw, input int half);
    return dw + 1 + cw + clog2(half + 1);
  endfunction
endpackage

// File: rtl/xwin_sym_mac.sv
// xwin_sym_mac: three-stage symmetric pre-add, multiply and sum datapath with shared enable.
module xwin_sym_mac
  import x_window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS = 5,
  parameter int COEF_W = 8,
  parameter logic [(TAPS/2+1)*COEF_W-1:0] COEFS = DEF_COEFS,
  parameter int SUM_W = sum_w(DATA_W, COEF_W, TAPS/2)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic [TAPS-1:0][DATA_W-1:0]   win,
  output logic [SUM_W-1:0]              sum
);
  localparam int HALF = TAPS / 2;
  localparam int PW = DATA_W + 1;
  localparam int MW = PW + COEF_W;
  logic [HALF:0][PW-1:0] pre;
  logic [HALF:0][MW-1:0] prod;
  logic [SUM_W-1:0] acc;
  always_comb begin
    acc = '0;
    for (int j = 0; j <= HALF; j++) acc += SUM_W'(prod[j]);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      prod <= '0;
      sum <= '0;
    end else if (en) begin
      for (int j = 0; j < HALF; j++) pre[j] <= PW'(win[j]) + PW'(win[TAPS-1-j]);
      pre[HALF] <= PW'(win[HALF]);
      for (int j = 0; j <= HALF; j++) prod[j] <= MW'(pre[j]) * MW'(COEFS[j*COEF_W +: COEF_W]);
      sum <= acc;
    end
  end
endmodule

// File: rtl/x_window_sym_fir.sv
// x_window_sym_fir: horizontal symmetric FIR with border replication on a stallable pixel stream.
// Define XWIN_ROUND_EN to round half up before the normalising shift; otherwise the result truncates.
module x_window_sym_fir
  import x_window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS = 5,
  parameter int COEF_W = 8,
  parameter logic [(TAPS/2+1)*COEF_W-1:0] COEFS = DEF_COEFS,
  parameter int NORM_SHIFT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sol,
  input  logic              in_eol,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sol,
  output logic              out_eol,
  input  logic              out_ready,
  output logic              err_sol
);
  localparam int HALF = TAPS / 2;
  localparam int SUM_W = sum_w(DATA_W, COEF_W, HALF);
  localparam int PEND_W = clog2(HALF + 1);
`ifdef XWIN_ROUND_EN
  localparam logic [SUM_W:0] RND = (SUM_W+1)'(1) << (NORM_SHIFT - 1);
`else
  localparam logic [SUM_W:0] RND = '0;
`endif
  state_t state, state_d;
  logic [TAPS-1:0][DATA_W-1:0] win, win_d;
  logic [PEND_W-1:0] pend, pend_d;
  logic first, first_d, err_d;
  logic wv, ws, we, wv_d, ws_d, we_d;
  logic [2:0] v_p, s_p, e_p;
  logic pipe_en, acc, sol_acc;
  logic [SUM_W-1:0] mac_sum;
  logic [SUM_W:0] rs, sh;
  assign pipe_en = !out_valid | out_ready;
  assign in_ready = reset & pipe_en & (state != FLUSH);
  assign acc = in_valid & in_ready;
  assign sol_acc = acc & (in_sol | (state == IDLE));
  assign rs = {1'b0, mac_sum} + RND;
  assign sh = rs >> NORM_SHIFT;
  // pend counts accepted pixels whose column has not yet been emitted
  always_comb begin
    state_d = state;
    win_d = win;
    pend_d = pend;
    first_d = first;
    err_d = err_sol;
    wv_d = 1'b0;
    we_d = 1'b0;
    if (sol_acc) begin
      win_d = {TAPS{in_data}};
      pend_d = PEND_W'(1);
      first_d = 1'b1;
      err_d = err_sol | !in_sol | (state == RUN);
      state_d = in_eol ? FLUSH : RUN;
    end else if (acc) begin
      win_d = {in_data, win[TAPS-1:1]};
      wv_d = pend == PEND_W'(HALF);
      pend_d = wv_d ? pend : pend + 1'b1;
      state_d = in_eol ? FLUSH : RUN;
    end else if (state == FLUSH && pipe_en) begin
      win_d = {win[TAPS-1], win[TAPS-1:1]};
      wv_d = 1'b1;
      we_d = pend == PEND_W'(1);
      pend_d = pend - 1'b1;
      state_d = we_d ? IDLE : FLUSH;
    end
    ws_d = wv_d & first;
    if (wv_d) first_d = 1'b0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      win <= '0;
      pend <= '0;
      first <= 1'b0;
      err_sol <= 1'b0;
      {wv, ws, we} <= '0;
      {v_p, s_p, e_p} <= '0;
      out_valid <= 1'b0;
      out_sol <= 1'b0;
      out_eol <= 1'b0;
      out_data <= '0;
    end else if (pipe_en) begin
      state <= state_d;
      win <= win_d;
      pend <= pend_d;
      first <= first_d;
      err_sol <= err_d;
      {wv, ws, we} <= {wv_d, ws_d, we_d};
      v_p <= {v_p[1:0], wv};
      s_p <= {s_p[1:0], ws};
      e_p <= {e_p[1:0], we};
      out_valid <= v_p[2];
      out_sol <= s_p[2];
      out_eol <= e_p[2];
      out_data <= |sh[SUM_W:DATA_W] ? '1 : sh[DATA_W-1:0];
    end
  end
  xwin_sym_mac #(
    .DATA_W(DATA_W),
    .TAPS(TAPS),
    .COEF_W(COEF_W),
    .COEFS(COEFS),
    .SUM_W(SUM_W)
  ) u_mac (
    .clock(clock),
    .reset(reset),
    .en(pipe_en),
    .win(win),
    .sum(mac_sum)
  );
endmodule

// File: tb/tb_x_window_sym_fir.sv
// tb_x_window_sym_fir: directed lines with hand-computed columns checked through an output scoreboard.
module tb_x_window_sym_fir;
  logic clock = 0;
  logic reset = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_sol = 0, in_eol = 0, out_ready = 1;
  logic in_ready, out_valid, out_sol, out_eol, err_sol;
  logic [7:0] out_data;
  int checks = 0, failures = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_q;
  int pix[$], ex[$];
  bit bp = 0, gappy = 0;

  x_window_sym_fir dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_sol(in_sol), .in_eol(in_eol), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_sol(out_sol), .out_eol(out_eol),
    .out_ready(out_ready), .err_sol(err_sol)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    out_ready = bp ? !out_ready : 1'b1;
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out got=%0h exp=none", out_data);
      end else begin
        exp_q = sb.pop_front();
        chk("out{data,sol,eol}", int'({out_data, out_sol, out_eol}), int'(exp_q));
      end
    end
  end

  task automatic send_px(input logic [7:0] d, input logic s, input logic e);
    int t;
    logic r;
    t = 0;
    r = 0;
    if (gappy) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    in_data = d; in_sol = s; in_eol = e; in_valid = 1;
    while (!r && t < 200) begin
      @(negedge clock);
      r = in_ready;
      @(posedge clock);
      #1;
      t++;
    end
    if (!r) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=stalled exp=accepted");
    end
    in_valid = 0; in_sol = 0; in_eol = 0;
  endtask

  // sent < pix.size() abandons the line after 'sent' pixels
  task automatic send_line(input int sent);
    int n, cols;
    logic [7:0] d;
    n = pix.size();
    cols = sent == n ? n : sent - 2;
    for (int c = 0; c < cols; c++) begin
      d = 8'(ex[c]);
      sb.push_back({d, c == 0, sent == n && c == n - 1});
    end
    for (int i = 0; i < sent; i++) send_px(8'(pix[i]), i == 0, i == n - 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin @(posedge clock); #1; t++; end
    repeat (8) begin @(posedge clock); #1; end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sol", int'(out_sol), 0);
    chk("rst_out_eol", int'(out_eol), 0);
    chk("rst_err_sol", int'(err_sol), 0);
    chk("rst_in_ready", int'(in_ready), 0);
  endtask

  task automatic line_impulse();
    pix = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
`ifdef XWIN_ROUND_EN
    ex = '{0, 0, 6, 58, 128, 58, 6, 0, 0};
`else
    ex = '{0, 0, 5, 57, 127, 57, 5, 0, 0};
`endif
    send_line(9);
  endtask

  task automatic line_edge();
    pix = '{0, 0, 0, 0, 0, 200};
`ifdef XWIN_ROUND_EN
    ex = '{0, 0, 0, 5, 50, 150};
`else
    ex = '{0, 0, 0, 4, 50, 150};
`endif
    send_line(6);
  endtask

  task automatic line_two();
    pix = '{10, 250};
    ex = '{70, 190};
    send_line(2);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    chk_reset_outputs();
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1;

    pix = '{100, 100, 100, 100, 100, 100, 100, 100};
    ex = pix;
    send_line(8);
    wait_drain();
    line_impulse();
    wait_drain();
    line_edge();
    wait_drain();
    pix = '{200};
    ex = '{200};
    send_line(1);
    line_two();
    wait_drain();
    chk("err_sol_clean", int'(err_sol), 0);

    bp = 1; gappy = 1;
    line_impulse();
    line_edge();
    line_two();
    wait_drain();
    bp = 0; gappy = 0;
    @(posedge clock); #1;

    pix = '{10, 20, 30, 40};
`ifdef XWIN_ROUND_EN
    ex = '{13};
`else
    ex = '{12};
`endif
    send_line(3);
    pix = '{50, 50, 50, 50};
    ex = pix;
    send_line(4);
    wait_drain();
    chk("err_sol_set", int'(err_sol), 1);

    pix = '{100, 100, 100, 100, 100, 100, 100, 100};
    ex = pix;
    send_line(8);
    reset = 0;
    sb.delete();
    chk_reset_outputs();
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1;
    pix = '{200};
    ex = '{200};
    send_line(1);
    pix = '{50, 50, 50, 50};
    ex = pix;
    send_line(4);
    wait_drain();
    chk("err_sol_after_reset", int'(err_sol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
